load_store_unit: RTL and testbench

- Sits between the execute stage and the word-wide data `memory` block; it is the only master of the memory's wEn/address/write_data ports.
- Converts byte/halfword/word load and store requests into word accesses.
- Sub-word loads get byte-lane extraction plus sign/zero extension. Sub-word stores use a read-modify-write (RMW) sequence.
- Returns one response per accepted request.

---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide memory.
// Optional LSU_BOUNDS_CHECK_EN flags addresses above ADDR_WIDTH.
module load_store_unit #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_error,
    output logic                  mem_wEn,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_store;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wbuf;
    logic [31:0]           r_rdata;
    logic [1:0]            r_error;

    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_oob;
    logic                  w_unused_hi;
    logic [4:0]            w_shift;
    logic [31:0]           w_lane;
    logic [31:0]           w_loaded;
    logic [31:0]           w_small;
    logic [31:0]           w_mask;
    logic [31:0]           w_merged;

    assign w_accept = req_valid & (r_state == S_IDLE);

    // Alignment and reserved-size check on the incoming request
    always_comb begin
        w_misalign = 1'b0;
        unique case (req_size)
            2'b00: w_misalign = 1'b0;
            2'b01: w_misalign = req_addr[0];
            2'b10: w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

    assign w_unused_hi = |req_addr[31:ADDR_WIDTH];
`ifdef LSU_BOUNDS_CHECK_EN
    assign w_oob = w_unused_hi;
`else
    assign w_oob = 1'b0;
`endif

    // Byte-lane shift; halves are 2-aligned so the same shift works
    assign w_shift = {r_addr[1:0], 3'b000};
    assign w_lane  = mem_read_data >> w_shift;

    // Lane extraction with sign/zero extension for loads
    always_comb begin
        w_loaded = mem_read_data;
        unique case (r_size)
            2'b00: begin
                if (r_uns)
                    w_loaded = {24'b0, w_lane[7:0]};
                else
                    w_loaded = {{24{w_lane[7]}}, w_lane[7:0]};
            end
            2'b01: begin
                if (r_uns)
                    w_loaded = {16'b0, w_lane[15:0]};
                else
                    w_loaded = {{16{w_lane[15]}}, w_lane[15:0]};
            end
            default: w_loaded = mem_read_data;
        endcase
    end

    // Merge sub-word store data into the word read back from memory
    always_comb begin
        w_small = 32'h0000_FFFF;
        if (r_size == 2'b00)
            w_small = 32'h0000_00FF;
        w_mask   = w_small << w_shift;
        w_merged = (mem_read_data & ~w_mask)
                 | ((r_wbuf & w_small) << w_shift);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign | w_oob)
                        w_next = S_RESP;
                    else if (req_store && req_size == 2'b10)
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            S_RD:   w_next = S_WAIT;
            S_WAIT: w_next = r_store ? S_WR : S_RESP;
            S_WR:   w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, read sampling and write-buffer merge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_store <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wbuf  <= 32'b0;
            r_rdata <= 32'b0;
            r_error <= 2'b00;
        end else begin
            if (w_accept) begin
                r_store <= req_store;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_addr  <= req_addr[ADDR_WIDTH-1:0];
                r_wbuf  <= req_wdata;
                r_rdata <= 32'b0;
                r_error <= {w_oob, w_misalign};
            end
            if (r_state == S_WAIT) begin
                if (r_store)
                    r_wbuf <= w_merged;
                else
                    r_rdata <= w_loaded;
            end
        end
    end

    assign req_ready      = (r_state == S_IDLE);
    assign resp_valid     = (r_state == S_RESP);
    assign resp_rdata     = r_rdata;
    assign resp_error     = r_error;
    assign mem_wEn        = (r_state == S_WR) & ~reset;
    assign mem_address    = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_write_data = r_wbuf;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a registered-read memory and a
// byte-array reference model; honours LSU_BOUNDS_CHECK_EN.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_error;
    logic        mem_wEn;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:16383];
    logic [7:0]  rb  [0:65535];
    int          wen_cnt = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    load_store_unit #(.ADDR_WIDTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_wEn        (mem_wEn),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory: write on edge when wEn, registered read
    always @(posedge clock) begin
        if (mem_wEn) begin
            mem[mem_address[15:2]] <= mem_write_data;
            wen_cnt <= wen_cnt + 1;
        end
        mem_read_data <= mem[mem_address[15:2]];
    end

    function automatic logic [31:0] ref_word(input int base);
        int b;
        b = base & 16'hFFFC;
        return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
    endfunction

    task automatic run(input logic st, input logic [1:0] sz,
                       input logic un, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
        int          n;
        int          base;
        int          lat;
        int          w0;
        int          guard;
        logic        mis;
        logic        oob;
        logic [1:0]  e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          e_wen;
        longint      v;

        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a % 65536);
        mis  = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0)
            || (sz == 2'd2 && a % 4 != 0);
`ifdef LSU_BOUNDS_CHECK_EN
        oob  = (a / 65536) != 0;
`else
        oob  = 1'b0;
`endif
        e_err = {oob, mis};
        e_rd  = 32'd0;
        e_wen = 0;
        if (mis || oob) begin
            e_lat = 1;
        end else if (st) begin
            e_lat = (n == 4) ? 2 : 4;
            e_wen = 1;
            for (int i = 0; i < n; i++)
                rb[base+i] = 8'((wd >> (8 * i)) % 256);
        end else begin
            e_lat = 3;
            v = 0;
            for (int i = 0; i < n; i++)
                v = v + (longint'(rb[base+i]) << (8 * i));
            if (!un && n < 4 && v >= (64'd1 << (8 * n - 1)))
                v = v - (64'd1 << (8 * n));
            e_rd = 32'(v);
        end

        @(negedge clock);
        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a;
        req_wdata    = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        w0 = wen_cnt;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clock);
            #1;
            lat++;
        end
        n_vec++;
        if (!resp_valid) begin
            n_bad++;
            $display("FAIL %s timeout: no resp_valid", tag);
        end
        n_vec++;
        if (lat !== e_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d",
                     tag, lat, e_lat);
        end
        n_vec++;
        if (resp_rdata !== e_rd) begin
            n_bad++;
            $display("FAIL %s rdata: got %h want %h",
                     tag, resp_rdata, e_rd);
        end
        n_vec++;
        if (resp_error !== e_err) begin
            n_bad++;
            $display("FAIL %s error: got %b want %b",
                     tag, resp_error, e_err);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_resp: ready %b valid %b want 1 0",
                     tag, req_ready, resp_valid);
        end
        n_vec++;
        if (wen_cnt - w0 != e_wen) begin
            n_bad++;
            $display("FAIL %s wen_pulses: got %0d want %0d",
                     tag, wen_cnt - w0, e_wen);
        end
        if (st && e_wen == 1) begin
            n_vec++;
            if (mem[base/4] !== ref_word(base)) begin
                n_bad++;
                $display("FAIL %s mem_word: got %h want %h",
                         tag, mem[base/4], ref_word(base));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0
            || resp_rdata !== 32'd0 || resp_error !== 2'd0
            || mem_wEn !== 1'b0 || mem_address !== 16'd0
            || mem_write_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: rdy %b v %b rd %h e %b we %b a %h wd %h want 1 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_error,
                     mem_wEn, mem_address, mem_write_data);
        end
    endtask

    task automatic test_init();
        for (int i = 0; i < 16; i++)
            run(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, "init_sw");
    endtask

    task automatic test_directed();
        run(1'b1, 2'd2, 1'b0, 32'h4, 32'hDEADBEEF, "sw4");
        run(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "lw4");
        run(1'b1, 2'd0, 1'b0, 32'h5, 32'h000000A5, "sb5");
        n_vec++;
        if (mem[1] !== 32'hDEADA5EF) begin
            n_bad++;
            $display("FAIL sb5_word: got %h want deada5ef", mem[1]);
        end
        run(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, "lb5");
        run(1'b0, 2'd0, 1'b1, 32'h5, 32'h0, "lbu5");
        run(1'b1, 2'd1, 1'b0, 32'h6, 32'h00001234, "sh6");
        n_vec++;
        if (mem[1] !== 32'h1234A5EF) begin
            n_bad++;
            $display("FAIL sh6_word: got %h want 1234a5ef", mem[1]);
        end
        run(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, "lh6");
        run(1'b0, 2'd1, 1'b0, 32'h4, 32'h0, "lh4");
    endtask

    task automatic test_errors();
        run(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, "lw6_mis");
        run(1'b1, 2'd1, 1'b0, 32'h5, 32'hFFFF, "sh5_mis");
        run(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, "size11");
    endtask

    task automatic test_reset_mid_op();
        int w0;
        int seen;
        run(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, "pre_sw8");
        @(negedge clock);
        req_valid    = 1'b1;
        req_store    = 1'b1;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h8;
        req_wdata    = 32'h000000EE;
        w0 = wen_cnt;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid ready: got %b want 1", req_ready);
        end
        seen = 0;
        repeat (6) begin
            if (resp_valid === 1'b1)
                seen++;
            @(posedge clock);
            #1;
        end
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rst_mid resp: got %0d pulses want 0", seen);
        end
        n_vec++;
        if (wen_cnt != w0 || mem[2] !== 32'h11223344) begin
            n_bad++;
            $display("FAIL rst_mid mem: got %h (%0d writes) want 11223344 (0)",
                     mem[2], wen_cnt - w0);
        end
    endtask

    task automatic test_bounds();
        run(1'b0, 2'd2, 1'b0, 32'h00010000, 32'h0, "lw_oob");
        run(1'b0, 2'd1, 1'b0, 32'h00020003, 32'h0, "lh_oob_mis");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] hi;
        for (int i = 0; i < 150; i++) begin
            hi = ($urandom_range(0, 7) == 0) ? ($urandom << 16) : 0;
            a  = hi | 32'($urandom_range(0, 63));
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom, "rand");
        end
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        test_reset();
        test_init();
        test_directed();
        test_errors();
        test_reset_mid_op();
        test_bounds();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
